// File: rtl/silife_pkg.sv
// Shared constants and types for SiLife cells.
package silife_pkg;

    localparam int STATE_DEAD  = 0;
    localparam int STATE_ALIVE = 1;
    localparam int NBR_CNT_W   = 4;

    typedef logic [8:0] rule_mask_t;

    localparam rule_mask_t RULE_B3  = 9'h008;
    localparam rule_mask_t RULE_S23 = 9'h00C;

endpackage

// File: rtl/silife_nbr_count.sv
// Popcount of the eight neighbour alive bits.
module silife_nbr_count
    import silife_pkg::*;
(
    input  logic [7:0]           i_nbr,
    output logic [NBR_CNT_W-1:0] o_cnt
);

    logic [NBR_CNT_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum + NBR_CNT_W'(i_nbr[i]);
        end
    end

    assign o_cnt = w_sum;

endmodule

// File: rtl/silife_gen_cell.sv
// One SiLife grid cell running a programmable B/S/C Generations rule.
module silife_gen_cell
    import silife_pkg::*;
#(
    parameter  int STATES = 2,
    localparam int SW     = (STATES > 2) ? $clog2(STATES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nw,
    input  logic          n,
    input  logic          ne,
    input  logic          e,
    input  logic          se,
    input  logic          s,
    input  logic          sw,
    input  logic          w,
    input  logic          step,
    input  rule_mask_t    birth_mask,
    input  rule_mask_t    survive_mask,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_data,
    output logic          out,
    output logic [SW-1:0] state,
    output logic          changed
);

    localparam logic [SW-1:0] S_DEAD  = SW'(STATE_DEAD);
    localparam logic [SW-1:0] S_ALIVE = SW'(STATE_ALIVE);
    localparam logic [SW-1:0] S_LAST  = SW'(STATES - 1);
    localparam logic [SW-1:0] S_FADE  = SW'((STATES > 2) ? 2 : 0);

    logic [SW-1:0]        r_state;
    logic                 r_changed;
    logic [NBR_CNT_W-1:0] w_cnt;
    logic [SW-1:0]        w_step_next;
    logic [SW-1:0]        w_wr_next;

    silife_nbr_count u_cnt (
        .i_nbr ({nw, n, ne, e, se, s, sw, w}),
        .o_cnt (w_cnt)
    );

    // Dying states advance unconditionally; neighbours only matter at 0 and 1.
    always_comb begin
        w_step_next = r_state;
        if (r_state == S_DEAD) begin
            w_step_next = birth_mask[w_cnt] ? S_ALIVE : S_DEAD;
        end else if (r_state == S_ALIVE) begin
            w_step_next = survive_mask[w_cnt] ? S_ALIVE : S_FADE;
        end else if (r_state == S_LAST) begin
            w_step_next = S_DEAD;
        end else begin
            w_step_next = r_state + SW'(1);
        end
    end

    assign w_wr_next = (32'(wr_data) >= STATES) ? S_DEAD : wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_DEAD;
            r_changed <= 1'b0;
        end else if (wr_en) begin
            r_state   <= w_wr_next;
            r_changed <= (w_wr_next != r_state);
        end else if (step) begin
            r_state   <= w_step_next;
            r_changed <= (w_step_next != r_state);
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign state   = r_state;
    assign out     = (r_state == S_ALIVE);
    assign changed = r_changed;

endmodule

// File: tb/tb_silife_gen_cell.sv
// Directed bench: classic Life, 4-state decay and 6-state clamp instances.
module tb_silife_gen_cell;

    logic       clk = 1'b0;
    logic       reset, step, wr_en;
    logic [7:0] nb;
    logic [8:0] bm, sm;
    logic [2:0] wd;

    logic       o2, c2, o4, c4, o6, c6;
    logic [0:0] s2;
    logic [1:0] s4;
    logic [2:0] s6;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    silife_gen_cell #(.STATES(2)) u2 (
        .clk(clk), .reset(reset),
        .nw(nb[7]), .n(nb[6]), .ne(nb[5]), .e(nb[4]),
        .se(nb[3]), .s(nb[2]), .sw(nb[1]), .w(nb[0]),
        .step(step), .birth_mask(bm), .survive_mask(sm),
        .wr_en(wr_en), .wr_data(wd[0:0]),
        .out(o2), .state(s2), .changed(c2)
    );

    silife_gen_cell #(.STATES(4)) u4 (
        .clk(clk), .reset(reset),
        .nw(nb[7]), .n(nb[6]), .ne(nb[5]), .e(nb[4]),
        .se(nb[3]), .s(nb[2]), .sw(nb[1]), .w(nb[0]),
        .step(step), .birth_mask(bm), .survive_mask(sm),
        .wr_en(wr_en), .wr_data(wd[1:0]),
        .out(o4), .state(s4), .changed(c4)
    );

    silife_gen_cell #(.STATES(6)) u6 (
        .clk(clk), .reset(reset),
        .nw(nb[7]), .n(nb[6]), .ne(nb[5]), .e(nb[4]),
        .se(nb[3]), .s(nb[2]), .sw(nb[1]), .w(nb[0]),
        .step(step), .birth_mask(bm), .survive_mask(sm),
        .wr_en(wr_en), .wr_data(wd),
        .out(o6), .state(s6), .changed(c6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        reset = 1'b0;
        step  = 1'b0;
        wr_en = 1'b0;
        wd    = 3'd0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        nb = 8'hFF; step = 1'b1; wr_en = 1'b1; wd = 3'd1;
        reset = 1'b1;
        tick();
        idle_in();
        n_cmp++;
        if (s2 !== 1'b0 || o2 !== 1'b0 || c2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset2: state=%0d out=%0d chg=%0d want 0/0/0", s2, o2, c2);
        end
        n_cmp++;
        if (s4 !== 2'd0 || o4 !== 1'b0 || c4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset4: state=%0d out=%0d chg=%0d want 0/0/0", s4, o4, c4);
        end
    endtask

    task automatic test_conway();
        do_reset();
        nb = 8'b1110_0000; step = 1'b1;
        tick();
        n_cmp++;
        if (s2 !== 1'b1 || o2 !== 1'b1 || c2 !== 1'b1) begin
            n_err++;
            $display("FAIL conway_birth: state=%0d out=%0d chg=%0d want 1/1/1", s2, o2, c2);
        end
        nb = 8'b0110_0000;
        tick();
        n_cmp++;
        if (s2 !== 1'b1 || c2 !== 1'b0) begin
            n_err++;
            $display("FAIL conway_survive: state=%0d chg=%0d want 1/0", s2, c2);
        end
        nb = 8'hFF;
        tick();
        n_cmp++;
        if (s2 !== 1'b0 || o2 !== 1'b0 || c2 !== 1'b1) begin
            n_err++;
            $display("FAIL conway_overcrowd: state=%0d out=%0d chg=%0d want 0/0/1", s2, o2, c2);
        end
        idle_in();
    endtask

    task automatic test_decay();
        logic [1:0] exp_s [3];
        exp_s = '{2'd2, 2'd3, 2'd0};
        do_reset();
        nb = 8'h00; wr_en = 1'b1; wd = 3'd1;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (s4 !== 2'd1 || o4 !== 1'b1 || c4 !== 1'b1) begin
            n_err++;
            $display("FAIL decay_write1: state=%0d out=%0d chg=%0d want 1/1/1", s4, o4, c4);
        end
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (s4 !== exp_s[i] || o4 !== 1'b0 || c4 !== 1'b1) begin
                n_err++;
                $display("FAIL decay_seq%0d: state=%0d out=%0d chg=%0d want %0d/0/1",
                         i, s4, o4, c4, exp_s[i]);
            end
        end
        step = 1'b0; wr_en = 1'b1; wd = 3'd2;
        tick();
        wr_en = 1'b0; step = 1'b1; nb = 8'b1110_0000;
        tick();
        n_cmp++;
        if (s4 !== 2'd3 || o4 !== 1'b0) begin
            n_err++;
            $display("FAIL decay_norebirth: state=%0d out=%0d want 3/0", s4, o4);
        end
        idle_in();
    endtask

    task automatic test_birth_zero();
        do_reset();
        nb = 8'h00; bm = 9'h001; step = 1'b1;
        tick();
        n_cmp++;
        if (s2 !== 1'b1 || o2 !== 1'b1) begin
            n_err++;
            $display("FAIL birth_zero: state=%0d out=%0d want 1/1", s2, o2);
        end
        bm = 9'h008;
        idle_in();
    endtask

    task automatic test_priority();
        do_reset();
        nb = 8'b1110_0000; wr_en = 1'b1; wd = 3'd3; step = 1'b1;
        tick();
        n_cmp++;
        if (s4 !== 2'd3 || c4 !== 1'b1) begin
            n_err++;
            $display("FAIL prio_write: state=%0d chg=%0d want 3/1", s4, c4);
        end
        n_cmp++;
        if (s6 !== 3'd3) begin
            n_err++;
            $display("FAIL prio_write6: state=%0d want 3", s6);
        end
        wd = 3'd7;
        tick();
        n_cmp++;
        if (s6 !== 3'd0 || c6 !== 1'b1) begin
            n_err++;
            $display("FAIL clamp: state=%0d chg=%0d want 0/1", s6, c6);
        end
        n_cmp++;
        if (s4 !== 2'd3 || c4 !== 1'b0) begin
            n_err++;
            $display("FAIL rewrite_same: state=%0d chg=%0d want 3/0", s4, c4);
        end
        wd = 3'd3; reset = 1'b1;
        tick();
        n_cmp++;
        if (s4 !== 2'd0 || c4 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_over_wr: state=%0d chg=%0d want 0/0", s4, c4);
        end
        idle_in();
    endtask

    task automatic test_hold();
        do_reset();
        wr_en = 1'b1; wd = 3'd2;
        tick();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            nb = (i % 2 == 0) ? 8'hFF : 8'b1110_0000;
            tick();
            n_cmp++;
            if (s4 !== 2'd2 || c4 !== 1'b0) begin
                n_err++;
                $display("FAIL hold%0d: state=%0d chg=%0d want 2/0", i, s4, c4);
            end
        end
    endtask

    initial begin
        idle_in();
        nb = 8'h00;
        bm = 9'h008;
        sm = 9'h00C;
        test_reset();
        test_conway();
        test_decay();
        test_birth_zero();
        test_priority();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
